// File: rtl/hex_pkg.sv
// -----------------------------------------------------------------------------
// hex_pkg
// Shared definitions for the seven-segment hex display controller:
//   - GLYPH_AL     : 16-entry glyph table, active-low form, bit order g..a
//   - SEG_BLANK_AL : all-segments-off pattern, active-low form
//   - state_e      : update FSM state encoding
//   - apply_polarity() : converts an active-low pattern to the selected polarity
// -----------------------------------------------------------------------------
package hex_pkg;

  localparam int SEG_W = 7;

  // Segment patterns are {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [SEG_W-1:0] SEG_BLANK_AL = 7'h7F;

  // Entry 15 is listed first so that GLYPH_AL[n] selects the glyph for nibble n.
  localparam logic [15:0][SEG_W-1:0] GLYPH_AL = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
    7'h03, 7'h08, 7'h18, 7'h00,   // B A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } state_e;

  function automatic logic [SEG_W-1:0] apply_polarity(input logic [SEG_W-1:0] pat_al,
                                                      input logic            active_low);
    return active_low ? pat_al : ~pat_al;
  endfunction

endpackage

// File: rtl/hex_glyph.sv
// -----------------------------------------------------------------------------
// hex_glyph
// Combinational hex nibble to seven-segment decode in the selected polarity.
// Ports:
//   nibble_i : 4-bit hex value
//   glyph_o  : 7-bit segment pattern {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex_glyph
  import hex_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] glyph_o
);

  assign glyph_o = apply_polarity(GLYPH_AL[nibble_i], ACTIVE_LOW != 0);

endmodule

// File: rtl/hex_display_ctrl.sv
// -----------------------------------------------------------------------------
// hex_display_ctrl
// Multi-digit seven-segment hex display controller. A load captures the value
// into a shadow register, then the digit registers are rewritten one per cycle
// from the most significant digit down, through a single shared glyph decoder.
// Optional leading-zero blanking and a free-running per-digit blink mask.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   load     : capture value/blank_lz (ignored while busy)
//   value    : 4*NUM_DIGITS hex nibbles, digit 0 in bits [3:0]
//   blank_lz : leading-zero blanking enable, captured with value
//   blink_en : per-digit blink enable, applied live
//   busy     : high while the digit registers are being rewritten
//   seg      : 7*NUM_DIGITS segment outputs, digit k in bits [7k+6:7k]
// -----------------------------------------------------------------------------
module hex_display_ctrl
  import hex_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic                    busy,
  output logic [7*NUM_DIGITS-1:0] seg
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(BLINK_DIV);

  localparam logic [IDX_W-1:0] IDX_MSD    = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(BLINK_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_BLANK  = apply_polarity(SEG_BLANK_AL, ACTIVE_LOW != 0);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic                   allz_q,  allz_d;
  logic [PRE_W-1:0]       pre_q,   pre_d;
  logic                   phase_q, phase_d;
  logic [SEG_W-1:0]       dig_q [NUM_DIGITS];
  logic [SEG_W-1:0]       dig_d [NUM_DIGITS];

  // Shadow copy of the load request; pure data, so no reset.
  logic [3:0]             nib_q [NUM_DIGITS];
  logic                   blz_q;

  logic                   cap_en;
  logic [3:0]             cur_nib;
  logic [SEG_W-1:0]       cur_glyph;
  logic                   cur_blank;

  assign cur_nib = nib_q[idx_q];

  hex_glyph #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_glyph (
    .nibble_i(cur_nib),
    .glyph_o (cur_glyph)
  );

  // allz_q means every nibble above idx_q is zero; digit 0 is always shown.
  assign cur_blank = blz_q && allz_q && (cur_nib == 4'd0) && (idx_q != '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    allz_d  = allz_q;
    dig_d   = dig_q;
    cap_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        allz_d = 1'b1;
        if (load) begin
          cap_en  = 1'b1;
          idx_d   = IDX_MSD;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        dig_d[idx_q] = cur_blank ? SEG_BLANK : cur_glyph;
        allz_d       = allz_q && (cur_nib == 4'd0);
        if (idx_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Blink prescaler runs regardless of the update FSM.
  always_comb begin
    pre_d   = pre_q + 1'b1;
    phase_d = phase_q;
    if (pre_q == PRE_LAST) begin
      pre_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      allz_q  <= 1'b1;
      pre_q   <= '0;
      phase_q <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        dig_q[k] <= SEG_BLANK;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      allz_q  <= allz_d;
      pre_q   <= pre_d;
      phase_q <= phase_d;
      dig_q   <= dig_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_en) begin
      blz_q <= blank_lz;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        nib_q[k] <= value[4*k +: 4];
      end
    end
  end

  assign busy = (state_q == ST_UPDATE);

  // Blink only masks the output; the stored digit registers are untouched.
  always_comb begin
    seg = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      seg[7*k +: 7] = (blink_en[k] && phase_q) ? SEG_BLANK : dig_q[k];
    end
  end

endmodule
